timer_counter_core: RTL and testbench

// - Consumer side of the count-enable interface: takes the cnt_en strobe from the

---
 rtl/timer_counter_if.sv | 31 +++
 rtl/timer_counter_core.sv | 91 +++++++++
 tb/tb_timer_counter_core.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// Register-block / count-control side bundle for the 64-bit timer counter core.
interface timer_counter_if;
  logic        cnt_en;
  logic        timer_en;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        cnt_wr_lo;
  logic        cnt_wr_hi;
  logic        cmp_wr_lo;
  logic        cmp_wr_hi;
  logic        int_en;
  logic        int_st_clr;
  logic [63:0] cnt_val;
  logic [63:0] cmp_val;
  logic        int_st;
  logic        tim_int;

  modport master (
    output cnt_en, timer_en, wdata, wstrb,
    output cnt_wr_lo, cnt_wr_hi, cmp_wr_lo, cmp_wr_hi,
    output int_en, int_st_clr,
    input  cnt_val, cmp_val, int_st, tim_int
  );

  modport slave (
    input  cnt_en, timer_en, wdata, wstrb,
    input  cnt_wr_lo, cnt_wr_hi, cmp_wr_lo, cmp_wr_hi,
    input  int_en, int_st_clr,
    output cnt_val, cmp_val, int_st, tim_int
  );
endinterface

// File: rtl/timer_counter_core.sv
// 64-bit free-running timer with byte-strobed counter/compare writes,
// sticky match status and maskable interrupt output.
module timer_counter_core #(
  parameter logic [63:0] CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  timer_counter_if.slave  bus
);

  logic [31:0] cnt_lo_q, cnt_hi_q;
  logic [31:0] cnt_lo_d, cnt_hi_d;
  logic [31:0] cmp_lo_q, cmp_hi_q;
  logic [31:0] cmp_lo_d, cmp_hi_d;
  logic        timer_en_q;
  logic        int_st_q, int_st_d;
  logic        en_fall;
  logic        inc;
  logic [32:0] lo_sum;
  logic [31:0] hi_sum;
  logic        match;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign en_fall = timer_en_q & ~bus.timer_en;
  assign inc     = bus.cnt_en & bus.timer_en;
  assign lo_sum  = {1'b0, cnt_lo_q} + 33'd1;
  assign hi_sum  = cnt_hi_q + 32'd1;
  assign match   = ({cnt_hi_q, cnt_lo_q} == {cmp_hi_q, cmp_lo_q});

  // Each half resolves independently: write, then disable-clear, then increment.
  // A written lo half produces no carry, so hi stays put in that case.
  always_comb begin
    cnt_lo_d = cnt_lo_q;
    cnt_hi_d = cnt_hi_q;
    if (bus.cnt_wr_lo)  cnt_lo_d = byte_merge(cnt_lo_q, bus.wdata, bus.wstrb);
    else if (en_fall)   cnt_lo_d = '0;
    else if (inc)       cnt_lo_d = lo_sum[31:0];

    if (bus.cnt_wr_hi)  cnt_hi_d = byte_merge(cnt_hi_q, bus.wdata, bus.wstrb);
    else if (en_fall)   cnt_hi_d = '0;
    else if (inc && !bus.cnt_wr_lo && lo_sum[32]) cnt_hi_d = hi_sum;
  end

  always_comb begin
    cmp_lo_d = cmp_lo_q;
    cmp_hi_d = cmp_hi_q;
    if (bus.cmp_wr_lo) cmp_lo_d = byte_merge(cmp_lo_q, bus.wdata, bus.wstrb);
    if (bus.cmp_wr_hi) cmp_hi_d = byte_merge(cmp_hi_q, bus.wdata, bus.wstrb);
  end

  // Set dominates clear so status cannot drop while the match persists.
  always_comb begin
    int_st_d = int_st_q;
    if (match)               int_st_d = 1'b1;
    else if (bus.int_st_clr) int_st_d = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_lo_q   <= '0;
      cnt_hi_q   <= '0;
      cmp_lo_q   <= CMP_RST_VAL[31:0];
      cmp_hi_q   <= CMP_RST_VAL[63:32];
      timer_en_q <= 1'b0;
      int_st_q   <= 1'b0;
    end else begin
      cnt_lo_q   <= cnt_lo_d;
      cnt_hi_q   <= cnt_hi_d;
      cmp_lo_q   <= cmp_lo_d;
      cmp_hi_q   <= cmp_hi_d;
      timer_en_q <= bus.timer_en;
      int_st_q   <= int_st_d;
    end
  end

  assign bus.cnt_val = {cnt_hi_q, cnt_lo_q};
  assign bus.cmp_val = {cmp_hi_q, cmp_lo_q};
  assign bus.int_st  = int_st_q;
  assign bus.tim_int = int_st_q & bus.int_en;

endmodule

// File: tb/tb_timer_counter_core.sv
// Scoreboard bench for timer_counter_core: a behavioural model queues the
// expected post-edge outputs; a monitor pops and compares after every edge.
module tb_timer_counter_core;

  logic sys_clk;
  logic sys_rst_n;

  timer_counter_if bus();

  timer_counter_core #(.CMP_RST_VAL(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [63:0] cnt;
    logic [63:0] cmp;
    logic        ist;
    logic        tim;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_cnt;
  logic [63:0] m_cmp;
  logic        m_ist;
  logic        m_prev_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_val & ~mask) | (wd & mask);
  endfunction

  task automatic model_reset();
    m_cnt     = '0;
    m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
    m_ist     = 1'b0;
    m_prev_en = 1'b0;
  endtask

  task automatic clear_pulses();
    bus.cnt_en     = 1'b0;
    bus.cnt_wr_lo  = 1'b0;
    bus.cnt_wr_hi  = 1'b0;
    bus.cmp_wr_lo  = 1'b0;
    bus.cmp_wr_hi  = 1'b0;
    bus.int_st_clr = 1'b0;
  endtask

  // Called just after a falling edge with inputs already set: predict the
  // state after the coming rising edge, queue it, advance one cycle.
  task automatic step();
    logic [63:0] sum, nc;
    logic        fall, inc, match;
    exp_t        e;
    fall  = m_prev_en & ~bus.timer_en;
    inc   = bus.cnt_en & bus.timer_en;
    sum   = m_cnt + (inc ? 64'd1 : 64'd0);
    match = (m_cnt == m_cmp);
    nc    = m_cnt;
    if (bus.cnt_wr_lo)      nc[31:0] = merge(m_cnt[31:0], bus.wdata, bus.wstrb);
    else if (fall)          nc[31:0] = 32'd0;
    else                    nc[31:0] = sum[31:0];
    if (bus.cnt_wr_hi)      nc[63:32] = merge(m_cnt[63:32], bus.wdata, bus.wstrb);
    else if (fall)          nc[63:32] = 32'd0;
    else if (bus.cnt_wr_lo) nc[63:32] = m_cnt[63:32];
    else                    nc[63:32] = sum[63:32];
    if (bus.cmp_wr_lo) m_cmp[31:0]  = merge(m_cmp[31:0], bus.wdata, bus.wstrb);
    if (bus.cmp_wr_hi) m_cmp[63:32] = merge(m_cmp[63:32], bus.wdata, bus.wstrb);
    m_ist     = match | (m_ist & ~bus.int_st_clr);
    m_cnt     = nc;
    m_prev_en = bus.timer_en;
    e.cnt = m_cnt;
    e.cmp = m_cmp;
    e.ist = m_ist;
    e.tim = m_ist & bus.int_en;
    exp_q.push_back(e);
    @(negedge sys_clk);
    clear_pulses();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_cnt(input logic [63:0] v);
    bus.wdata = v[31:0];  bus.wstrb = 4'hF; bus.cnt_wr_lo = 1'b1; step();
    bus.wdata = v[63:32]; bus.wstrb = 4'hF; bus.cnt_wr_hi = 1'b1; step();
  endtask

  task automatic wr_cmp(input logic [63:0] v);
    bus.wdata = v[31:0];  bus.wstrb = 4'hF; bus.cmp_wr_lo = 1'b1; step();
    bus.wdata = v[63:32]; bus.wstrb = 4'hF; bus.cmp_wr_hi = 1'b1; step();
  endtask

  // Monitor: compares every queued prediction one time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cnt_val", bus.cnt_val, e.cnt);
        check("cmp_val", bus.cmp_val, e.cmp);
        check("int_st",  {63'd0, bus.int_st},  {63'd0, e.ist});
        check("tim_int", {63'd0, bus.tim_int}, {63'd0, e.tim});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_n    = 1'b0;
    bus.timer_en = 1'b0;
    bus.int_en   = 1'b0;
    bus.wdata    = '0;
    bus.wstrb    = '0;
    clear_pulses();
    model_reset();
    repeat (3) @(negedge sys_clk);
    check("rst_cnt", bus.cnt_val, 64'd0);
    check("rst_cmp", bus.cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_int_st", {63'd0, bus.int_st}, 64'd0);
    check("rst_tim_int", {63'd0, bus.tim_int}, 64'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    bus.timer_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.cnt_en = 1'b1;
      step();
      idle(2);
    end
    check("five_pulses", bus.cnt_val, 64'd5);

    wr_cnt(64'h0000_0000_FFFF_FFFF);
    bus.cnt_en = 1'b1; step();
    check("carry_32", bus.cnt_val, 64'h0000_0001_0000_0000);
    wr_cnt(64'hFFFF_FFFF_FFFF_FFFF);
    bus.cnt_en = 1'b1; step();
    check("wrap_64", bus.cnt_val, 64'd0);

    wr_cnt(64'h0000_0000_AABB_CCDD);
    bus.wdata = 32'h1234_5678; bus.wstrb = 4'b0011;
    bus.cnt_wr_lo = 1'b1; bus.cnt_en = 1'b1; step();
    check("partial_wr_lo", bus.cnt_val, 64'h0000_0000_AABB_5678);

    // carry suppression when hi is written alongside an overflowing increment
    wr_cnt(64'h0000_0007_FFFF_FFFF);
    bus.wdata = 32'h0000_0020; bus.wstrb = 4'hF;
    bus.cnt_wr_hi = 1'b1; bus.cnt_en = 1'b1; step();
    check("wr_hi_drops_carry", bus.cnt_val, 64'h0000_0020_0000_0000);

    wr_cnt(64'd0);
    wr_cmp(64'd10);
    bus.int_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.cnt_en = 1'b1; step();
    end
    step();
    check("match_int_st", {63'd0, bus.int_st}, 64'd1);
    check("match_tim_int", {63'd0, bus.tim_int}, 64'd1);
    bus.int_en = 1'b0; step();
    check("masked_tim_int", {63'd0, bus.tim_int}, 64'd0);
    check("masked_int_st", {63'd0, bus.int_st}, 64'd1);

    bus.int_st_clr = 1'b1; step();
    check("clr_during_match", {63'd0, bus.int_st}, 64'd1);
    bus.cnt_en = 1'b1; step();
    bus.int_st_clr = 1'b1; step();
    check("clr_after_match", {63'd0, bus.int_st}, 64'd0);

    wr_cnt(64'h55);
    bus.timer_en = 1'b0; step();
    check("disable_clear", bus.cnt_val, 64'd0);
    bus.cnt_en = 1'b1; step();
    bus.timer_en = 1'b1; step();

    for (int i = 0; i < 400; i++) begin
      bus.timer_en = ($urandom_range(0, 19) != 0);
      bus.int_en   = $urandom_range(0, 1);
      bus.cnt_en   = ($urandom_range(0, 2) != 0);
      bus.int_st_clr = ($urandom_range(0, 7) == 0);
      bus.wstrb    = 4'($urandom_range(0, 15));
      bus.wdata    = $urandom;
      case ($urandom_range(0, 15))
        0: bus.cnt_wr_lo = 1'b1;
        1: bus.cnt_wr_hi = 1'b1;
        2: begin bus.cnt_wr_lo = 1'b1; bus.cnt_wr_hi = 1'b1; end
        3: begin
             bus.wstrb = 4'hF;
             bus.wdata = m_cnt[31:0] + 32'($urandom_range(0, 3));
             bus.cmp_wr_lo = 1'b1;
           end
        4: begin
             bus.wstrb = 4'hF;
             bus.wdata = m_cnt[63:32];
             bus.cmp_wr_hi = 1'b1;
           end
        5: bus.cmp_wr_lo = 1'b1;
        default: ;
      endcase
      step();
    end

    bus.timer_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cnt_en = 1'b1; step();
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_cnt", bus.cnt_val, 64'd0);
    check("async_rst_cmp", bus.cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("async_rst_int_st", {63'd0, bus.int_st}, 64'd0);
    check("async_rst_tim_int", {63'd0, bus.tim_int}, 64'd0);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.cnt_en = $urandom_range(0, 1);
      step();
    end

    @(negedge sys_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
